// File: rtl/uart_line_receiver.sv
// 8N1 UART receiver with 16x oversampling, feeding a small line editor
// (store / backspace / CR-commit) with an echo register and a registered read port.
module uart_line_receiver #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    output logic          line_valid,
    output logic [LW-1:0] line_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          line_ack,
    output logic          echo_valid,
    output logic [7:0]    echo_data,
    input  logic          echo_ready,
    output logic          frame_err,
    output logic          overflow
);
    localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {ED_EDIT, ED_HOLD} ed_state_t;

    logic            rx_meta_q, rx_sync_q;
    logic [DW-1:0]   div_q;
    logic            tick;
    rx_state_t       rx_state_q;
    logic            armed_q;
    logic [3:0]      tick_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      byte_q;
    logic            byte_strobe_q;
    logic            frame_err_q;

    ed_state_t       ed_state_q;
    logic [LW-1:0]   count_q;
    logic [LW-1:0]   line_len_q;
    logic            line_valid_q;
    logic            overflow_q;
    logic            echo_valid_q;
    logic [7:0]      echo_data_q;
    logic [7:0]      rd_data_q;
    logic [7:0]      mem [DEPTH];

    logic            is_print, is_bs, is_cr, is_full;
    logic            wr_en;
    logic            echo_push;
    logic [7:0]      echo_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            div_q     <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            div_q     <= tick ? '0 : div_q + 1'b1;
        end
    end

    assign tick = (div_q == DW'(DIV - 1));

    // Start bit is re-checked at its midpoint; every later sample lands mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q    <= RX_IDLE;
            armed_q       <= 1'b0;
            tick_cnt_q    <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            byte_q        <= '0;
            byte_strobe_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            byte_strobe_q <= 1'b0;
            frame_err_q   <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_sync_q) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        armed_q    <= 1'b0;
                        tick_cnt_q <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (tick_cnt_q == 4'd7) begin
                            tick_cnt_q <= '0;
                            bit_idx_q  <= '0;
                            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (tick_cnt_q == 4'd15) begin
                            shift_q   <= {rx_sync_q, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                            if (bit_idx_q == 3'd7) rx_state_q <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (tick_cnt_q == 4'd15) begin
                            if (rx_sync_q) begin
                                byte_strobe_q <= 1'b1;
                                byte_q        <= shift_q;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                            armed_q    <= 1'b0;
                            rx_state_q <= RX_IDLE;
                        end
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign is_print = (byte_q >= 8'h20) && (byte_q <= 8'h7E);
    assign is_bs    = (byte_q == 8'h08) || (byte_q == 8'h7F);
    assign is_cr    = (byte_q == 8'h0D);
    assign is_full  = (count_q == LW'(DEPTH));

    always_comb begin
        wr_en     = 1'b0;
        echo_push = 1'b0;
        echo_byte = byte_q;
        if (byte_strobe_q && ed_state_q == ED_EDIT) begin
            if (is_print && !is_full) begin
                wr_en     = 1'b1;
                echo_push = 1'b1;
            end else if (is_bs && count_q != '0) begin
                echo_push = 1'b1;
                echo_byte = 8'h08;
            end else if (is_cr) begin
                echo_push = 1'b1;
                echo_byte = 8'h0D;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ed_state_q   <= ED_EDIT;
            count_q      <= '0;
            line_len_q   <= '0;
            line_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            echo_valid_q <= 1'b0;
            echo_data_q  <= '0;
        end else begin
            overflow_q <= 1'b0;
            if (echo_valid_q && echo_ready) echo_valid_q <= 1'b0;
            // A pending, un-accepted echo wins; the newer echo is lost.
            if (echo_push && (!echo_valid_q || echo_ready)) begin
                echo_valid_q <= 1'b1;
                echo_data_q  <= echo_byte;
            end
            case (ed_state_q)
                ED_EDIT: begin
                    if (byte_strobe_q) begin
                        if (is_print) begin
                            if (is_full) overflow_q <= 1'b1;
                            else         count_q    <= count_q + 1'b1;
                        end else if (is_bs) begin
                            if (count_q != '0) count_q <= count_q - 1'b1;
                        end else if (is_cr) begin
                            line_len_q   <= count_q;
                            line_valid_q <= 1'b1;
                            ed_state_q   <= ED_HOLD;
                        end
                    end
                end
                ED_HOLD: begin
                    if (byte_strobe_q) overflow_q <= 1'b1;
                    if (line_ack) begin
                        line_valid_q <= 1'b0;
                        count_q      <= '0;
                        ed_state_q   <= ED_EDIT;
                    end
                end
                default: ed_state_q <= ED_EDIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[count_q[AW-1:0]] <= byte_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= mem[rd_addr];
    end

    assign line_valid = line_valid_q;
    assign line_len   = line_len_q;
    assign rd_data    = rd_data_q;
    assign echo_valid = echo_valid_q;
    assign echo_data  = echo_data_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_uart_line_receiver.sv
// Directed bench for uart_line_receiver: expected echoes and line lengths are queued
// by the stimulus thread and checked by an independent monitor.
module tb_uart_line_receiver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx = 1'b1;
    logic       line_valid;
    logic [2:0] line_len;
    logic [1:0] rd_addr = 2'd0;
    logic [7:0] rd_data;
    logic       line_ack = 1'b0;
    logic       echo_valid;
    logic [7:0] echo_data;
    logic       echo_ready = 1'b1;
    logic       frame_err;
    logic       overflow;

    uart_line_receiver #(
        .CLK_HZ(1600000),
        .BAUD  (100000),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .line_valid(line_valid),
        .line_len  (line_len),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .line_ack  (line_ack),
        .echo_valid(echo_valid),
        .echo_data (echo_data),
        .echo_ready(echo_ready),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         ovf_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] echo_q[$];
    int         len_q[$];
    logic       ovf_prev = 1'b0;
    logic       ferr_prev = 1'b0;
    logic       lv_prev = 1'b0;
    logic [7:0] mon_e;
    int         mon_l;
    int         base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: consumes DUT outputs independently of the stimulus thread.
    always @(negedge clk) begin
        if (echo_valid && echo_ready) begin
            if (echo_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_echo: got 0x%02h, expected no echo", echo_data);
            end else begin
                mon_e = echo_q.pop_front();
                $display("echo 0x%02h (expected 0x%02h)", echo_data, mon_e);
                check("echo_data", 32'(echo_data), 32'(mon_e));
            end
        end
        if (line_valid && !lv_prev) begin
            if (len_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_line: got len %0d, expected no line", line_len);
            end else begin
                mon_l = len_q.pop_front();
                $display("line committed len %0d (expected %0d)", line_len, mon_l);
                check("line_len", 32'(line_len), 32'(mon_l));
            end
        end
        if (overflow) begin
            check("overflow_width", 32'(ovf_prev), 32'd0);
            ovf_cnt++;
        end
        if (frame_err) begin
            check("frame_err_width", 32'(ferr_prev), 32'd0);
            ferr_cnt++;
        end
        ovf_prev  = overflow;
        ferr_prev = frame_err;
        lv_prev   = line_valid;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        rx = stop_bit;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    task automatic wait_line();
        int t = 0;
        while (!line_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!line_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL line_timeout: got line_valid 0, expected 1 within 300 cycles");
        end
    endtask

    task automatic read_check(input int addr, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = 2'(addr);
        @(negedge clk);
        check("rd_data", 32'(rd_data), 32'(exp));
    endtask

    task automatic ack_line();
        @(negedge clk);
        line_ack = 1'b1;
        @(negedge clk);
        line_ack = 1'b0;
        check("line_valid_after_ack", 32'(line_valid), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("reset_outputs",
              32'({line_valid, line_len, rd_data, echo_valid, echo_data, frame_err, overflow}),
              32'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 1: "AB" CR
        echo_q.push_back(8'h41); echo_q.push_back(8'h42); echo_q.push_back(8'h0D);
        len_q.push_back(2);
        send(8'h41); send(8'h42); send(8'h0D);
        wait_line();
        read_check(0, 8'h41);
        read_check(1, 8'h42);
        ack_line();

        // 2: "AX" BS "B" CR
        echo_q.push_back(8'h41); echo_q.push_back(8'h58); echo_q.push_back(8'h08);
        echo_q.push_back(8'h42); echo_q.push_back(8'h0D);
        len_q.push_back(2);
        send(8'h41); send(8'h58); send(8'h08); send(8'h42); send(8'h0D);
        wait_line();
        read_check(0, 8'h41);
        read_check(1, 8'h42);
        ack_line();

        // 3: backspace on empty line, then empty commit
        echo_q.push_back(8'h0D);
        len_q.push_back(0);
        send(8'h08); send(8'h0D);
        wait_line();
        ack_line();

        // 4: "abcde" CR with DEPTH 4
        base = ovf_cnt;
        echo_q.push_back(8'h61); echo_q.push_back(8'h62);
        echo_q.push_back(8'h63); echo_q.push_back(8'h64);
        send(8'h61); send(8'h62); send(8'h63); send(8'h64);
        check("overflow_before_full", 32'(ovf_cnt), 32'(base));
        send(8'h65);
        check("overflow_on_e", 32'(ovf_cnt), 32'(base + 1));
        echo_q.push_back(8'h0D);
        len_q.push_back(4);
        send(8'h0D);
        wait_line();
        for (int i = 0; i < 4; i++) read_check(i, 8'h61 + 8'(i));
        ack_line();

        // 5: bad stop bit and a short glitch between stored bytes
        base = ferr_cnt;
        echo_q.push_back(8'h48);
        send(8'h48);
        send_byte(8'h55, 1'b0);
        check("frame_err_count", 32'(ferr_cnt), 32'(base + 1));
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_frame_err", 32'(ferr_cnt), 32'(base + 1));
        echo_q.push_back(8'h0D);
        len_q.push_back(1);
        send(8'h0D);
        wait_line();
        read_check(0, 8'h48);

        // 6: byte in HOLD, ack, new line, then reset mid-byte
        base = ovf_cnt;
        send(8'h5A);
        check("overflow_in_hold", 32'(ovf_cnt), 32'(base + 1));
        ack_line();
        echo_q.push_back(8'h51); echo_q.push_back(8'h0D);
        len_q.push_back(1);
        send(8'h51); send(8'h0D);
        wait_line();
        read_check(0, 8'h51);

        base = ferr_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (48 + 5) @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("no_line_after_reset", 32'(line_valid), 32'd0);
        check("no_frame_err_after_reset", 32'(ferr_cnt), 32'(base));
        echo_q.push_back(8'h0D);
        len_q.push_back(0);
        send(8'h0D);
        wait_line();

        repeat (10) @(negedge clk);
        check("echo_queue_drained", 32'(echo_q.size()), 32'd0);
        check("len_queue_drained", 32'(len_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
